// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter for an 8-input packet mux with per-grant beat limit.
module bus_arbiter8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Req,
    input  logic [7:0] Last,
    input  logic       Ready,
    output logic [2:0] Sel,
    output logic [7:0] Grant,
    output logic       Valid
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [2:0] ptr, ptr_n, sel_n, arb_ptr, win;
    logic [CW-1:0] count, count_n;
    logic xfer, rel;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            Sel   <= '0;
            Grant <= '0;
            ptr   <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            Sel   <= sel_n;
            Grant <= (state_n == GRANT) ? 8'd1 << sel_n : 8'd0;
            ptr   <= ptr_n;
            count <= count_n;
        end
    end
    // on release the search starts just past the released requester, in the same cycle
    always_comb begin
        xfer    = Valid && Ready;
        rel     = (state == GRANT) && (!Req[Sel] || (xfer && (Last[Sel] || count == CW'(MAX_HOLD - 1))));
        arb_ptr = rel ? Sel + 3'd1 : ptr;
        win     = arb_ptr;
        for (int i = 7; i >= 0; i--)
            if (Req[arb_ptr + 3'(i)]) win = arb_ptr + 3'(i);
        state_n = state;
        sel_n   = Sel;
        ptr_n   = ptr;
        count_n = count;
        if (state == IDLE || rel) begin
            ptr_n   = arb_ptr;
            state_n = (|Req) ? GRANT : IDLE;
            sel_n   = (|Req) ? win : Sel;
            count_n = '0;
        end else if (xfer) begin
            count_n = count + 1'b1;
        end
    end
    always_comb begin
        Valid = (state == GRANT) && Req[Sel];
    end
endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: randomized and directed checks of bus_arbiter8 against a cycle-level model.
module tb_bus_arbiter8;
    localparam int MAX_HOLD = 4;
    logic       Clk = 0, Reset = 0, Ready = 0;
    logic [7:0] Req = 0, Last = 0;
    logic [2:0] Sel;
    logic [7:0] Grant;
    logic       Valid;
    int errors = 0, checks = 0;
    bit m_busy;
    int m_sel, m_ptr, m_beats, m_xfers;
    logic [2:0] exp_sel;
    logic [7:0] exp_grant;
    logic       exp_valid;

    bus_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Last(Last), .Ready(Ready),
        .Sel(Sel), .Grant(Grant), .Valid(Valid)
    );

    always #5 Clk = ~Clk;

    function automatic int arb(input int p, input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
    endtask

    // apply inputs for one cycle and form the outputs the model expects during it
    task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic rd);
        @(negedge Clk);
        Req = r; Last = l; Ready = rd;
        #1;
        exp_grant = m_busy ? 8'd1 << m_sel : 8'd0;
        exp_sel   = 3'(m_sel);
        exp_valid = m_busy && r[m_sel];
    endtask

    // model of what the coming rising edge does with the inputs now applied
    task automatic advance();
        int w;
        bit v, x;
        if (!m_busy) begin
            w = arb(m_ptr, Req);
            if (w >= 0) begin m_busy = 1; m_sel = w; m_beats = 0; end
        end else begin
            v = Req[m_sel];
            x = v && Ready;
            if (x) m_xfers++;
            if (!v || (x && (Last[m_sel] || m_beats + 1 == MAX_HOLD))) begin
                m_ptr = (m_sel + 1) % 8;
                w = arb(m_ptr, Req);
                if (w >= 0) begin m_sel = w; m_beats = 0; end
                else m_busy = 0;
            end else if (x) m_beats++;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Req = 0; Last = 0; Ready = 0; Reset = 1;
        #2 Reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Req = 0; Reset = 1;
        #1;
        checks++;
        if ({Sel, Grant, Valid} !== 12'h0) begin
            errors++;
            $display("FAIL reset_hold: sel/grant/valid got %0d/%h/%b want 0/00/0", Sel, Grant, Valid);
        end
        #1 Reset = 0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            drive(8'h00, 8'h00, 1'b1);
            checks++;
            if ({Sel, Grant, Valid} !== 12'h0 || {Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: sel/grant/valid got %0d/%h/%b want 0/00/0", i, Sel, Grant, Valid);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(8'hFF, 8'hFF, 1'b1);
            checks++;
            if ({Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid}) begin
                errors++;
                $display("FAIL rr cyc %0d: sel/grant/valid got %0d/%h/%b want %0d/%h/%b", i, Sel, Grant, Valid, exp_sel, exp_grant, exp_valid);
            end
            if (i > 0) begin
                checks++;
                if (Sel !== 3'((i - 1) % 8) || Valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_order cyc %0d: sel/valid got %0d/%b want %0d/1", i, Sel, Valid, (i - 1) % 8);
                end
            end
            advance();
        end
    endtask

    task automatic test_max_hold();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(8'h04, 8'h00, 1'b1);
            checks++;
            if ({Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid} || (i > 0 && Grant !== 8'h04)) begin
                errors++;
                $display("FAIL max_hold cyc %0d: sel/grant/valid got %0d/%h/%b want %0d/%h/%b", i, Sel, Grant, Valid, exp_sel, exp_grant, exp_valid);
            end
            advance();
        end
        for (int i = 0; i < 12; i++) begin
            drive(8'h0C, 8'h00, 1'b1);
            checks++;
            if ({Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid}) begin
                errors++;
                $display("FAIL max_hold_pair cyc %0d: sel/grant/valid got %0d/%h/%b want %0d/%h/%b", i, Sel, Grant, Valid, exp_sel, exp_grant, exp_valid);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(8'h20, 8'h00, 1'b0);
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(8'h20, 8'h20 * (i % 2), 1'b0);
            checks++;
            if (Sel !== 3'd5 || Grant !== 8'h20 || Valid !== 1'b1) begin
                errors++;
                $display("FAIL stall cyc %0d: sel/grant/valid got %0d/%h/%b want 5/20/1", i, Sel, Grant, Valid);
            end
            advance();
        end
        drive(8'hA0, 8'h20, 1'b1);
        advance();
        drive(8'hA0, 8'h00, 1'b0);
        checks++;
        if (Sel !== 3'd7 || Grant !== 8'h80 || {Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid}) begin
            errors++;
            $display("FAIL stall_release: sel/grant got %0d/%h want 7/80", Sel, Grant);
        end
        advance();
    endtask

    task automatic test_drop();
        do_reset();
        drive(8'h04, 8'h00, 1'b0);
        advance();
        drive(8'h82, 8'h00, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(8'h82, 8'h00, 1'b0);
            checks++;
            if (Sel !== 3'd7 || Grant !== 8'h80 || Valid !== 1'b1) begin
                errors++;
                $display("FAIL drop_hold cyc %0d: sel/grant/valid got %0d/%h/%b want 7/80/1", i, Sel, Grant, Valid);
            end
            advance();
        end
        drive(8'h02, 8'h80, 1'b1);
        checks++;
        if (Valid !== 1'b0 || Sel !== 3'd7) begin
            errors++;
            $display("FAIL drop_valid: sel/valid got %0d/%b want 7/0", Sel, Valid);
        end
        advance();
        drive(8'h02, 8'h00, 1'b0);
        checks++;
        if (Sel !== 3'd1 || Grant !== 8'h02 || {Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid}) begin
            errors++;
            $display("FAIL drop_regrant: sel/grant got %0d/%h want 1/02", Sel, Grant);
        end
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(8'h40, 8'h00, 1'b0);
        advance();
        drive(8'h40, 8'h00, 1'b0);
        checks++;
        if (Sel !== 3'd6 || Grant !== 8'h40) begin
            errors++;
            $display("FAIL areset_pre: sel/grant got %0d/%h want 6/40", Sel, Grant);
        end
        #2 Reset = 1;
        #1;
        checks++;
        if ({Sel, Grant, Valid} !== 12'h0) begin
            errors++;
            $display("FAIL areset_now: sel/grant/valid got %0d/%h/%b want 0/00/0", Sel, Grant, Valid);
        end
        Reset = 0;
        Req = 8'h41;
        model_reset();
        advance();
        drive(8'h41, 8'h00, 1'b0);
        checks++;
        if (Sel !== 3'd0 || Grant !== 8'h01 || {Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid}) begin
            errors++;
            $display("FAIL areset_restart: sel/grant got %0d/%h want 0/01", Sel, Grant);
        end
        advance();
    endtask

    task automatic test_random();
        logic [7:0] r, l;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom) & 8'($urandom | $urandom);
            l = 8'($urandom) & 8'($urandom);
            drive(r, l, 1'($urandom_range(0, 3) != 0));
            checks++;
            if ({Sel, Grant, Valid} !== {exp_sel, exp_grant, exp_valid} || $countones(Grant) > 1) begin
                errors++;
                $display("FAIL random cyc %0d: sel/grant/valid got %0d/%h/%b want %0d/%h/%b", i, Sel, Grant, Valid, exp_sel, exp_grant, exp_valid);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        m_xfers = 0;
        test_reset();
        test_round_robin();
        test_max_hold();
        test_stall();
        test_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 4, maximum accepted beats per grant before forced release (legal range 1..255).
REQ-002 SHALL have port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Req  input  8  per-requester request; bit i = requester i has data on mux input i (A=0 .. H=7).
REQ-005 SHALL have port: Last  input  8  bit i = requester i's current beat is the final beat of its packet.
REQ-006 SHALL have port: Ready  input  1  downstream sink accepts the current beat.
REQ-007 SHALL have port: Sel  output  3  registered select driving the Mux8To1 Sel input.
REQ-008 SHALL have port: Grant  output  8  registered one-hot grant; Grant[Sel]=1 while in GRANT state, else all zero.
REQ-009 SHALL have port: Valid  output  1  beat on mux output Y is valid (combinational: state==GRANT && Req[Sel]).

Function
REQ-010 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-011 SHALL keep a 3-bit round-robin pointer Ptr; search order Ptr, Ptr+1, ..., Ptr+7 (mod 8); first set Req bit wins.
REQ-012 IDLE: if Req!=0, SHALL go to GRANT next edge with Sel=winner, Grant=1<<winner, beat count=0; if Req==0, stay IDLE, Sel holds last value.
REQ-013 Latency: Req rising in IDLE at edge n SHALL give Grant/Valid asserted after edge n+1 (one-cycle arbitration).
REQ-014 Transfer SHALL occur exactly on a cycle with Valid && Ready; each transfer increments beat count by 1.
REQ-015 Release condition (evaluated in GRANT each cycle): (transfer && Last[Sel]) OR (transfer && count+1==MAX_HOLD) OR (!Req[Sel]).
REQ-016 On release, Ptr SHALL become Sel+1 mod 8 (released requester becomes lowest priority).
REQ-017 On release, SHALL re-arbitrate in the same cycle using current Req and the updated Ptr order: if any Req bit set, go directly to GRANT with new winner and count=0 (no bubble); else go to IDLE with Grant=0.
REQ-018 Re-arbitration on release SHALL include the released requester; if it is the only one requesting, it is re-granted (count reset to 0).
REQ-019 No release in GRANT: Sel, Grant, Ptr SHALL hold; count holds when no transfer.
REQ-020 Valid && !Ready SHALL hold Sel/Grant stable indefinitely (no timeout); data on Y is the requester's responsibility.
REQ-021 Req[Sel] dropping while granted SHALL release per REQ-015 without counting a transfer, even if Ready=1.
REQ-022 Last[i] for i!=Sel SHALL be ignored; Last[Sel] without a transfer SHALL be ignored.
REQ-023 Beat counter SHALL be ceil(log2(MAX_HOLD+1)) bits, never exceed MAX_HOLD-1 in state, never wrap.
REQ-024 MAX_HOLD=1 SHALL release after every transfer.
REQ-025 Grant SHALL be one-hot or zero at all times; never two bits set.

Reset
REQ-026 Reset=1 SHALL immediately (no clock) force state=IDLE, Sel=0, Grant=8'h00, Ptr=0, count=0; Valid consequently 0.
REQ-027 Reset asserted mid-grant SHALL abort the grant with no further transfer; after deassertion arbitration restarts from Ptr=0.
REQ-028 First rising edge after Reset deassertion SHALL perform normal IDLE arbitration.

Verification
REQ-029 Reset then Req=8'h00 for 5 cycles -> Grant=8'h00, Sel=0, Valid=0 throughout.
REQ-030 Req=8'hFF, Ready=1, Last=8'hFF constantly -> grants in order 0,1,2,...,7,0, one beat each, Valid high every cycle after first grant (no bubbles).
REQ-031 MAX_HOLD=4, Req=8'h04 only, Ready=1, Last=0 -> Sel=2, release after 4 transfers, immediately re-granted to 2, count restarts; Grant stays 8'h04.
REQ-032 Grant to requester 5, Ready=0 for 10 cycles -> Sel=5, Grant=8'h20, Valid=1, count=0 held; then Ready=1 with Last[5]=1 -> one transfer, Ptr=6.
REQ-033 Req=8'h82 with Ptr=3 -> requester 7 granted first; then requester 1 after 7 releases; Req[7] dropped mid-grant -> release with no transfer counted.
REQ-034 Reset pulsed asynchronously mid-grant of requester 6 -> Grant=8'h00, Sel=0 before next edge; with Req=8'h41 after release, requester 0 granted first.
